// File: rtl/slip_tx_if.sv
// Source-side byte streams and the SLIP encoder handshake for slip_tx_arbiter.
// master = the arbiter, slave = the sources and encoder around it.
interface slip_tx_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_valid;
  logic [8*NUM_REQ-1:0] i_data;
  logic [NUM_REQ-1:0]   i_last;
  logic [NUM_REQ-1:0]   o_ready;
  logic [NUM_REQ-1:0]   o_grant;
  logic [NUM_REQ-1:0]   o_frame_done;
  logic                 o_frame_abort;
  logic                 o_busy;
  logic                 o_slip_start;
  logic                 o_slip_dv;
  logic [7:0]           o_slip_byte;
  logic                 o_slip_end;
  logic                 i_slip_done;

  modport master (
    input  i_valid, i_data, i_last, i_slip_done,
    output o_ready, o_grant, o_frame_done, o_frame_abort, o_busy,
           o_slip_start, o_slip_dv, o_slip_byte, o_slip_end
  );

  modport slave (
    output i_valid, i_data, i_last, i_slip_done,
    input  o_ready, o_grant, o_frame_done, o_frame_abort, o_busy,
           o_slip_start, o_slip_dv, o_slip_byte, o_slip_end
  );
endinterface

// File: rtl/slip_tx_arbiter.sv
// Round-robin, whole-frame arbiter sharing one SLIP encoder between NUM_REQ sources.
// A winner owns the encoder until its closing END completes or its stream stalls too long.
module slip_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic      clk,
  input  logic      reset,
  slip_tx_if.master bus
);
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_TIMEOUT);
  localparam logic [IDX_W-1:0]   RR_INIT   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_WAIT,
    S_FETCH,
    S_BYTE_WAIT,
    S_END_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   frame_done_q, frame_done_d;
  logic                 frame_abort_q, frame_abort_d;
  logic                 abort_q, abort_d;
  logic                 start_q, start_d;
  logic                 dv_q, dv_d;
  logic                 end_q, end_d;
  logic [7:0]           byte_q, byte_d;
  logic                 last_q, last_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic [7:0]           src_byte [NUM_REQ];
  logic [2*NUM_REQ-1:0] valid_x2;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 owner_valid;
  logic                 owner_last;
  logic [7:0]           owner_byte;
  logic                 xfer;
  logic [STALL_W-1:0]   stall_inc;
  logic                 stall_hit;
  logic                 done_in;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
    assign src_byte[gi]    = bus.i_data[8*gi +: 8];
    assign bus.o_ready[gi] = (state_q == S_FETCH) && grant_q[gi];
  end

  assign owner_valid = bus.i_valid[owner_q];
  assign owner_last  = bus.i_last[owner_q];
  assign owner_byte  = src_byte[owner_q];
  assign done_in     = bus.i_slip_done;
  assign xfer        = (state_q == S_FETCH) && owner_valid;
  assign stall_inc   = (stall_q == STALL_LIM) ? stall_q : stall_q + 1'b1;
  assign stall_hit   = (state_q == S_FETCH) && !owner_valid && (stall_inc == STALL_LIM);

  // Doubled request vector lets the search run rr+1 .. rr+NUM_REQ without a modulo on the index;
  // scanning far-to-near leaves the nearest requester as the winner.
  assign valid_x2 = {bus.i_valid, bus.i_valid};

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (valid_x2[int'(rr_q) + k]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_q          <= RR_INIT;
      owner_q       <= '0;
      grant_q       <= '0;
      frame_done_q  <= '0;
      frame_abort_q <= 1'b0;
      abort_q       <= 1'b0;
      start_q       <= 1'b0;
      dv_q          <= 1'b0;
      end_q         <= 1'b0;
      byte_q        <= 8'h00;
      last_q        <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      abort_q       <= abort_d;
      start_q       <= start_d;
      dv_q          <= dv_d;
      end_q         <= end_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      stall_q       <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (pick_found) state_d = S_START_WAIT;
      S_START_WAIT: if (done_in) state_d = S_FETCH;
      S_FETCH: begin
        if (xfer)           state_d = S_BYTE_WAIT;
        else if (stall_hit) state_d = S_END_WAIT;
      end
      S_BYTE_WAIT:  if (done_in) state_d = last_q ? S_END_WAIT : S_FETCH;
      S_END_WAIT:   if (done_in) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d          = rr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    abort_d       = abort_q;
    byte_d        = byte_q;
    last_d        = last_q;
    stall_d       = stall_q;
    start_d       = 1'b0;
    dv_d          = 1'b0;
    end_d         = 1'b0;
    frame_done_d  = '0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          abort_d           = 1'b0;
          start_d           = 1'b1;
        end
      end
      S_START_WAIT: if (done_in) stall_d = '0;
      S_FETCH: begin
        // A byte arriving on the timeout cycle still wins over the abort.
        if (xfer) begin
          byte_d = owner_byte;
          last_d = owner_last;
          dv_d   = 1'b1;
        end else begin
          stall_d = stall_inc;
          if (stall_hit) begin
            abort_d = 1'b1;
            end_d   = 1'b1;
          end
        end
      end
      S_BYTE_WAIT: begin
        if (done_in) begin
          if (last_q) end_d = 1'b1;
          else        stall_d = '0;
        end
      end
      S_END_WAIT: begin
        if (done_in) begin
          frame_done_d  = grant_q;
          frame_abort_d = abort_q;
          rr_d          = owner_q;
          grant_d       = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_frame_done  = frame_done_q;
  assign bus.o_frame_abort = frame_abort_q;
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_slip_start  = start_q;
  assign bus.o_slip_dv     = dv_q;
  assign bus.o_slip_byte   = byte_q;
  assign bus.o_slip_end    = end_q;
endmodule

// File: tb/tb_slip_tx_arbiter.sv
// Directed bench for slip_tx_arbiter: per-source byte queues, a fixed-latency encoder model,
// a table of single-frame vectors and hand sequences for arbitration, timeout and reset.
module tb_slip_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int STALL   = 8;
  localparam int ENC_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  slip_tx_if #(.NUM_REQ(NREQ)) bus();

  slip_tx_arbiter #(.NUM_REQ(NREQ), .STALL_TIMEOUT(STALL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [2:0]  len;
    logic [31:0] bytes;   // byte i at [8i+7:8i]
  } frame_vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0]      srcq [NREQ][$];   // {last, byte}
  int              enc_cnt;
  logic            done_drv;
  int              start_cnt, end_cnt, last_end_cyc;
  int              hs_cnt [NREQ];
  int              rdy_cnt [NREQ];
  logic [7:0]      byte_log [$];
  int              done_order [$];
  int              start_cyc [$];
  int              done_cyc [$];
  logic [NREQ-1:0] done_mask, grant_at_start;
  logic            done_abort, busy_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    start_cnt = 0; end_cnt = 0; last_end_cyc = 0;
    for (int k = 0; k < NREQ; k++) begin hs_cnt[k] = 0; rdy_cnt[k] = 0; end
    byte_log.delete(); done_order.delete(); start_cyc.delete(); done_cyc.delete();
    done_mask = '0; grant_at_start = '0; done_abort = 1'b0; busy_at_done = 1'b0;
  endtask

  task automatic drive_sources();
    logic [NREQ-1:0]   v, l;
    logic [8*NREQ-1:0] d;
    logic [8:0]        e;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (srcq[k].size() > 0) begin
        e          = srcq[k][0];
        v[k]       = 1'b1;
        l[k]       = e[8];
        d[8*k +: 8] = e[7:0];
      end
    end
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
  endtask

  task automatic push_frame(input int src, input int len, input logic [31:0] bytes);
    for (int i = 0; i < len; i++) srcq[src].push_back({(i == len - 1), bytes[8*i +: 8]});
  endtask

  // One clock: sample handshakes mid-cycle, observe registered outputs just after the edge,
  // then advance the encoder model and the source drivers.
  task automatic tick();
    logic [NREQ-1:0] acc, rdy;
    logic            pulse_any;
    @(negedge clk);
    rdy = reset ? '0 : bus.o_ready;
    acc = rdy & bus.i_valid;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NREQ; k++) begin
      if (rdy[k]) rdy_cnt[k]++;
      if (acc[k] && srcq[k].size() > 0) begin
        void'(srcq[k].pop_front());
        hs_cnt[k]++;
      end
    end
    pulse_any = bus.o_slip_start | bus.o_slip_dv | bus.o_slip_end;
    if (pulse_any)
      check("pulse_exclusive", $countones({bus.o_slip_start, bus.o_slip_dv, bus.o_slip_end}), 1);
    if (bus.o_slip_start) begin
      start_cnt++; grant_at_start = bus.o_grant; start_cyc.push_back(cyc);
    end
    if (bus.o_slip_dv) byte_log.push_back(bus.o_slip_byte);
    if (bus.o_slip_end) begin end_cnt++; last_end_cyc = cyc; end
    if (|bus.o_frame_done) begin
      done_mask = bus.o_frame_done; done_abort = bus.o_frame_abort; busy_at_done = bus.o_busy;
      done_cyc.push_back(cyc);
      for (int k = 0; k < NREQ; k++) if (bus.o_frame_done[k]) done_order.push_back(k);
      $display("frame done: owner_mask=%b abort=%0d cycle=%0d", bus.o_frame_done, bus.o_frame_abort, cyc);
    end
    done_drv = 1'b0;
    if (enc_cnt > 0) begin
      enc_cnt--;
      if (enc_cnt == 0) done_drv = 1'b1;
    end
    if (pulse_any) enc_cnt = ENC_LAT;
    bus.i_slip_done = done_drv;
    drive_sources();
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    for (int i = 0; i < budget && done_order.size() < n; i++) tick();
    check(name, done_order.size(), n);
  endtask

  task automatic do_frame(input frame_vec_t fv, input string tag);
    int src, len;
    src = int'(fv.src);
    len = int'(fv.len);
    clear_log();
    push_frame(src, len, fv.bytes);
    drive_sources();
    wait_frames(1, 200, {tag, "_done_count"});
    check({tag, "_start_cnt"}, start_cnt, 1);
    check({tag, "_grant"}, grant_at_start, 32'(1) << src);
    check({tag, "_byte_count"}, byte_log.size(), len);
    for (int i = 0; i < len && i < byte_log.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), byte_log[i], fv.bytes[8*i +: 8]);
    check({tag, "_end_cnt"}, end_cnt, 1);
    check({tag, "_done_mask"}, done_mask, 32'(1) << src);
    check({tag, "_abort"}, done_abort, 0);
    check({tag, "_handshakes"}, hs_cnt[src], len);
    check({tag, "_ready_cycles"}, rdy_cnt[src], len);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  // Waits until the first captured byte's done has been driven; returns that cycle.
  task automatic wait_first_byte_done(input string tag, output int d);
    logic ok;
    ok = 1'b0; d = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (byte_log.size() == 1 && done_drv) begin ok = 1'b1; d = cyc; break; end
    end
    check({tag, "_byte_done_seen"}, ok, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, bus.o_grant, 0);
    check({tag, "_ready"}, bus.o_ready, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_pulses"}, {bus.o_slip_start, bus.o_slip_dv, bus.o_slip_end}, 0);
    check({tag, "_done"}, {bus.o_frame_done, bus.o_frame_abort}, 0);
    check({tag, "_byte"}, bus.o_slip_byte, 0);
  endtask

  frame_vec_t vecs [4];
  int d_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{src: 2'd0, len: 3'd3, bytes: 32'h0033_2211};
    vecs[1] = '{src: 2'd2, len: 3'd2, bytes: 32'h0000_DBC0};
    vecs[2] = '{src: 2'd3, len: 3'd1, bytes: 32'h0000_007E};
    vecs[3] = '{src: 2'd1, len: 3'd4, bytes: 32'hFF00_C0DB};

    enc_cnt = 0; done_drv = 1'b0;
    bus.i_slip_done = 1'b0;
    drive_sources();
    clear_log();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Single-frame vectors: plain bytes, escape bytes, single-byte frame, longer frame.
    for (int v = 0; v < 4; v++) do_frame(vecs[v], $sformatf("vec%0d", v));

    // Src1 and src3 together from reset; src1 re-requests, so src3 must win the next round.
    reset = 1'b1; enc_cnt = 0; bus.i_slip_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    clear_log();
    push_frame(1, 2, 32'h0000_0201);
    push_frame(1, 1, 32'h0000_0003);
    push_frame(3, 1, 32'h0000_0031);
    drive_sources();
    wait_frames(3, 400, "rr_done_count");
    if (done_order.size() == 3) begin
      check("rr_first", done_order[0], 1);
      check("rr_second", done_order[1], 3);
      check("rr_third", done_order[2], 1);
    end
    if (start_cyc.size() == 3 && done_cyc.size() == 3) begin
      check("rr_gap1", start_cyc[1] - done_cyc[0], 1);
      check("rr_gap2", start_cyc[2] - done_cyc[1], 1);
    end
    check("rr_byte_count", byte_log.size(), 4);
    if (byte_log.size() == 4)
      check("rr_bytes", {byte_log[0], byte_log[1], byte_log[2], byte_log[3]}, 32'h0102_3103);

    // Stall timeout: one byte, then the source goes quiet.
    clear_log();
    srcq[0].push_back(9'h0AA);
    drive_sources();
    wait_first_byte_done("t4", d_cyc);
    wait_frames(1, 100, "t4_done_count");
    check("t4_end_delay", last_end_cyc - d_cyc, STALL + 1);
    check("t4_done_mask", done_mask, 1);
    check("t4_abort", done_abort, 1);
    check("t4_end_cnt", end_cnt, 1);
    check("t4_handshakes", hs_cnt[0], 1);

    // Reset while waiting on a byte: frame dropped with no done, then a fresh frame runs normally.
    clear_log();
    push_frame(0, 2, 32'h0000_6B5A);
    drive_sources();
    for (int i = 0; i < 100 && byte_log.size() == 0; i++) tick();
    check("t5_dv_seen", byte_log.size(), 1);
    reset = 1'b1;
    for (int k = 0; k < NREQ; k++) srcq[k].delete();
    drive_sources();
    tick();
    enc_cnt = 0; bus.i_slip_done = 1'b0;
    check_idle_outputs("t5_reset");
    reset = 1'b0;
    clear_log();
    repeat (6) tick();
    check("t5_no_done", done_order.size(), 0);
    check("t5_no_start", start_cnt, 0);
    do_frame('{src: 2'd0, len: 3'd1, bytes: 32'h0000_00A5}, "t5_new");

    // Byte arrives on the very cycle the stall count reaches its limit: accepted, no abort.
    clear_log();
    srcq[0].push_back(9'h0BB);
    drive_sources();
    wait_first_byte_done("t6", d_cyc);
    while (cyc < d_cyc + STALL) tick();
    srcq[0].push_back(9'h1CC);
    drive_sources();
    wait_frames(1, 100, "t6_done_count");
    check("t6_abort", done_abort, 0);
    check("t6_byte_count", byte_log.size(), 2);
    if (byte_log.size() == 2) check("t6_bytes", {byte_log[0], byte_log[1]}, 16'hBBCC);
    check("t6_end_cnt", end_cnt, 1);
    check("t6_handshakes", hs_cnt[0], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
